// File: rtl/rvfi_commit_tracker.sv
// RVFI commit tracker: per-ROB-entry trace record, emitted one cycle after commit.
// Optional protocol checker enabled by defining RVFI_TRACKER_CHECK_EN.
module rvfi_commit_tracker #(
  parameter int ROB_DEPTH = 16,
  localparam int IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch_valid,
  input  logic [IDX_W-1:0] dispatch_rob_id,
  input  logic [31:0]      dispatch_inst,
  input  logic [31:0]      dispatch_pc,
  input  logic [4:0]       dispatch_rs1_addr,
  input  logic [4:0]       dispatch_rs2_addr,
  input  logic [4:0]       dispatch_rd_addr,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_rob_id,
  input  logic [31:0]      wb_rs1_rdata,
  input  logic [31:0]      wb_rs2_rdata,
  input  logic [31:0]      wb_rd_wdata,
  input  logic [31:0]      wb_pc_wdata,
  input  logic             mem_valid,
  input  logic [IDX_W-1:0] mem_rob_id,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_rmask,
  input  logic [3:0]       mem_wmask,
  input  logic             commit_valid,
  input  logic [IDX_W-1:0] commit_rob_id,
  input  logic             flush,
  output logic             rvfi_valid,
  output logic [63:0]      rvfi_order,
  output logic [31:0]      rvfi_inst,
  output logic [31:0]      rvfi_pc_rdata,
  output logic [31:0]      rvfi_pc_wdata,
  output logic [4:0]       rvfi_rs1_addr,
  output logic [4:0]       rvfi_rs2_addr,
  output logic [4:0]       rvfi_rd_addr,
  output logic [31:0]      rvfi_rs1_rdata,
  output logic [31:0]      rvfi_rs2_rdata,
  output logic [31:0]      rvfi_rd_wdata,
  output logic [31:0]      rvfi_mem_addr,
  output logic [31:0]      rvfi_mem_rdata,
  output logic [31:0]      rvfi_mem_wdata,
  output logic [3:0]       rvfi_mem_rmask,
  output logic [3:0]       rvfi_mem_wmask,
  output logic             error
);

  logic [ROB_DEPTH-1:0] alloc_q, alloc_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [63:0]          order_q;

  logic [31:0] inst_q  [ROB_DEPTH];
  logic [31:0] pc_q    [ROB_DEPTH];
  logic [4:0]  rs1a_q  [ROB_DEPTH];
  logic [4:0]  rs2a_q  [ROB_DEPTH];
  logic [4:0]  rda_q   [ROB_DEPTH];
  logic [31:0] rs1d_q  [ROB_DEPTH];
  logic [31:0] rs2d_q  [ROB_DEPTH];
  logic [31:0] rdw_q   [ROB_DEPTH];
  logic [31:0] pcw_q   [ROB_DEPTH];
  logic [31:0] maddr_q [ROB_DEPTH];
  logic [31:0] mrd_q   [ROB_DEPTH];
  logic [31:0] mwd_q   [ROB_DEPTH];
  logic [3:0]  rmask_q [ROB_DEPTH];
  logic [3:0]  wmask_q [ROB_DEPTH];

  // Flush and reset suppress every update except the commit itself.
  logic dv, wv, mv;
  assign dv = dispatch_valid & ~flush & ~rst;
  assign wv = wb_valid & ~flush & ~rst;
  assign mv = mem_valid & ~flush & ~rst;

  logic wb_hit, mem_hit;
  assign wb_hit  = wv & (wb_rob_id == commit_rob_id);
  assign mem_hit = mv & (mem_rob_id == commit_rob_id);

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    if (flush) begin
      alloc_d = '0;
    end else begin
      if (commit_valid) alloc_d[commit_rob_id] = 1'b0;
      if (dispatch_valid) begin
        alloc_d[dispatch_rob_id] = 1'b1;
        done_d[dispatch_rob_id]  = 1'b0;
      end
      if (wb_valid) done_d[wb_rob_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (dv) begin
      inst_q[dispatch_rob_id]  <= dispatch_inst;
      pc_q[dispatch_rob_id]    <= dispatch_pc;
      rs1a_q[dispatch_rob_id]  <= dispatch_rs1_addr;
      rs2a_q[dispatch_rob_id]  <= dispatch_rs2_addr;
      rda_q[dispatch_rob_id]   <= dispatch_rd_addr;
      rmask_q[dispatch_rob_id] <= 4'd0;
      wmask_q[dispatch_rob_id] <= 4'd0;
    end
    if (wv) begin
      rs1d_q[wb_rob_id] <= wb_rs1_rdata;
      rs2d_q[wb_rob_id] <= wb_rs2_rdata;
      rdw_q[wb_rob_id]  <= wb_rd_wdata;
      pcw_q[wb_rob_id]  <= wb_pc_wdata;
    end
    if (mv) begin
      maddr_q[mem_rob_id] <= mem_addr;
      mrd_q[mem_rob_id]   <= mem_rdata;
      mwd_q[mem_rob_id]   <= mem_wdata;
      rmask_q[mem_rob_id] <= mem_rmask;
      wmask_q[mem_rob_id] <= mem_wmask;
    end
  end

  logic [4:0]  c_rs1a, c_rs2a, c_rda;
  logic [31:0] c_rs1d, c_rs2d, c_rdw, c_pcw;
  logic [31:0] c_maddr, c_mrd, c_mwd;
  logic [3:0]  c_rmask, c_wmask;

  always_comb begin
    c_rs1a  = rs1a_q[commit_rob_id];
    c_rs2a  = rs2a_q[commit_rob_id];
    c_rda   = rda_q[commit_rob_id];
    c_rs1d  = wb_hit ? wb_rs1_rdata : rs1d_q[commit_rob_id];
    c_rs2d  = wb_hit ? wb_rs2_rdata : rs2d_q[commit_rob_id];
    c_rdw   = wb_hit ? wb_rd_wdata : rdw_q[commit_rob_id];
    c_pcw   = wb_hit ? wb_pc_wdata : pcw_q[commit_rob_id];
    c_maddr = mem_hit ? mem_addr : maddr_q[commit_rob_id];
    c_mrd   = mem_hit ? mem_rdata : mrd_q[commit_rob_id];
    c_mwd   = mem_hit ? mem_wdata : mwd_q[commit_rob_id];
    c_rmask = mem_hit ? mem_rmask : rmask_q[commit_rob_id];
    c_wmask = mem_hit ? mem_wmask : wmask_q[commit_rob_id];
    if (c_rs1a == 5'd0) c_rs1d = 32'd0;
    if (c_rs2a == 5'd0) c_rs2d = 32'd0;
    if (c_rda == 5'd0)  c_rdw  = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_inst      <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_rdata <= '0;
      rvfi_mem_wdata <= '0;
      rvfi_mem_rmask <= '0;
      rvfi_mem_wmask <= '0;
      order_q        <= '0;
    end else begin
      rvfi_valid <= commit_valid;
      if (commit_valid) begin
        rvfi_order     <= order_q;
        order_q        <= order_q + 64'd1;
        rvfi_inst      <= inst_q[commit_rob_id];
        rvfi_pc_rdata  <= pc_q[commit_rob_id];
        rvfi_pc_wdata  <= c_pcw;
        rvfi_rs1_addr  <= c_rs1a;
        rvfi_rs2_addr  <= c_rs2a;
        rvfi_rd_addr   <= c_rda;
        rvfi_rs1_rdata <= c_rs1d;
        rvfi_rs2_rdata <= c_rs2d;
        rvfi_rd_wdata  <= c_rdw;
        rvfi_mem_addr  <= c_maddr;
        rvfi_mem_rdata <= c_mrd;
        rvfi_mem_wdata <= c_mwd;
        rvfi_mem_rmask <= c_rmask;
        rvfi_mem_wmask <= c_wmask;
      end
    end
  end

`ifdef RVFI_TRACKER_CHECK_EN
  logic err_q, err_d;
  logic bad_commit, bad_disp, bad_wb, bad_mem;

  always_comb begin
    bad_commit = commit_valid &
                 (~alloc_q[commit_rob_id] |
                  ~(done_q[commit_rob_id] | wb_hit));
    bad_disp   = dv & alloc_q[dispatch_rob_id] &
                 ~(commit_valid & (commit_rob_id == dispatch_rob_id));
    bad_wb     = wv & ~alloc_q[wb_rob_id];
    bad_mem    = mv & ~alloc_q[mem_rob_id];
    err_d      = err_q | bad_commit | bad_disp | bad_wb | bad_mem;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Randomized scoreboard bench for rvfi_commit_tracker.
// Reference model holds whole entries; monitor compares every cycle.
module tb_rvfi_commit_tracker;
  localparam int D = 16;
  localparam int W = $clog2(D);
`ifdef RVFI_TRACKER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic dispatch_valid, wb_valid, mem_valid, commit_valid, flush;
  logic [W-1:0] dispatch_rob_id, wb_rob_id, mem_rob_id, commit_rob_id;
  logic [31:0] dispatch_inst, dispatch_pc;
  logic [4:0]  dispatch_rs1_addr, dispatch_rs2_addr, dispatch_rd_addr;
  logic [31:0] wb_rs1_rdata, wb_rs2_rdata, wb_rd_wdata, wb_pc_wdata;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        rvfi_valid, error;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

  always #5 clk = ~clk;

  rvfi_commit_tracker #(.ROB_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_rob_id(dispatch_rob_id),
    .dispatch_inst(dispatch_inst), .dispatch_pc(dispatch_pc),
    .dispatch_rs1_addr(dispatch_rs1_addr),
    .dispatch_rs2_addr(dispatch_rs2_addr),
    .dispatch_rd_addr(dispatch_rd_addr),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
    .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata),
    .wb_rd_wdata(wb_rd_wdata), .wb_pc_wdata(wb_pc_wdata),
    .mem_valid(mem_valid), .mem_rob_id(mem_rob_id),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .flush(flush),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_inst(rvfi_inst), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .error(error)
  );

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst, pc_rdata, pc_wdata;
    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] rs1d, rs2d, rdw, maddr, mrd, mwd;
    logic [3:0]  rmask, wmask;
  } rec_t;

  typedef struct {
    bit          alloc, done;
    logic [31:0] inst, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1d, rs2d, rdw, pcw, maddr, mrd, mwd;
    logic [3:0]  rm, wm;
  } ent_t;

  ent_t        mdl [D];
  logic [63:0] cnt;
  rec_t        expq [$];
  int          ncmp = 0;
  int          nfail = 0;

  function automatic void chk(string nm, logic [511:0] act,
                              logic [511:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic idle();
    rst = 1'b0; flush = 1'b0;
    dispatch_valid = 0; wb_valid = 0; mem_valid = 0; commit_valid = 0;
    dispatch_rob_id = '0; wb_rob_id = '0; mem_rob_id = '0;
    commit_rob_id = '0;
    dispatch_inst = '0; dispatch_pc = '0;
    dispatch_rs1_addr = '0; dispatch_rs2_addr = '0; dispatch_rd_addr = '0;
    wb_rs1_rdata = '0; wb_rs2_rdata = '0; wb_rd_wdata = '0;
    wb_pc_wdata = '0;
    mem_addr = '0; mem_rdata = '0; mem_wdata = '0;
    mem_rmask = '0; mem_wmask = '0;
  endtask

  task automatic drv_disp(int id, logic [31:0] inst, logic [31:0] pc,
                          logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
    dispatch_valid = 1; dispatch_rob_id = W'(id);
    dispatch_inst = inst; dispatch_pc = pc;
    dispatch_rs1_addr = r1; dispatch_rs2_addr = r2; dispatch_rd_addr = rd;
  endtask

  task automatic drv_wb(int id, logic [31:0] d1, logic [31:0] d2,
                        logic [31:0] dw, logic [31:0] pw);
    wb_valid = 1; wb_rob_id = W'(id);
    wb_rs1_rdata = d1; wb_rs2_rdata = d2;
    wb_rd_wdata = dw; wb_pc_wdata = pw;
  endtask

  task automatic drv_mem(int id, logic [31:0] a, logic [31:0] rd,
                         logic [31:0] wd, logic [3:0] rm, logic [3:0] wm);
    mem_valid = 1; mem_rob_id = W'(id);
    mem_addr = a; mem_rdata = rd; mem_wdata = wd;
    mem_rmask = rm; mem_wmask = wm;
  endtask

  task automatic drv_commit(int id);
    commit_valid = 1; commit_rob_id = W'(id);
  endtask

  // Model: what the trace port should show for the inputs now applied.
  task automatic model_apply();
    ent_t e;
    rec_t r;
    if (rst) begin
      foreach (mdl[i]) begin mdl[i].alloc = 0; mdl[i].done = 0; end
      cnt = '0;
      return;
    end
    if (commit_valid) begin
      e = mdl[commit_rob_id];
      if (!flush && wb_valid && wb_rob_id == commit_rob_id) begin
        e.rs1d = wb_rs1_rdata; e.rs2d = wb_rs2_rdata;
        e.rdw = wb_rd_wdata; e.pcw = wb_pc_wdata;
      end
      if (!flush && mem_valid && mem_rob_id == commit_rob_id) begin
        e.maddr = mem_addr; e.mrd = mem_rdata; e.mwd = mem_wdata;
        e.rm = mem_rmask; e.wm = mem_wmask;
      end
      r.order = cnt; r.inst = e.inst;
      r.pc_rdata = e.pc; r.pc_wdata = e.pcw;
      r.rs1a = e.rs1; r.rs2a = e.rs2; r.rda = e.rd;
      r.rs1d = (e.rs1 == 0) ? 32'd0 : e.rs1d;
      r.rs2d = (e.rs2 == 0) ? 32'd0 : e.rs2d;
      r.rdw  = (e.rd == 0) ? 32'd0 : e.rdw;
      r.maddr = e.maddr; r.mrd = e.mrd; r.mwd = e.mwd;
      r.rmask = e.rm; r.wmask = e.wm;
      expq.push_back(r);
      cnt = cnt + 64'd1;
    end
    if (flush) begin
      foreach (mdl[i]) mdl[i].alloc = 0;
      return;
    end
    if (commit_valid) mdl[commit_rob_id].alloc = 0;
    if (dispatch_valid) begin
      mdl[dispatch_rob_id].alloc = 1; mdl[dispatch_rob_id].done = 0;
      mdl[dispatch_rob_id].inst = dispatch_inst;
      mdl[dispatch_rob_id].pc = dispatch_pc;
      mdl[dispatch_rob_id].rs1 = dispatch_rs1_addr;
      mdl[dispatch_rob_id].rs2 = dispatch_rs2_addr;
      mdl[dispatch_rob_id].rd = dispatch_rd_addr;
      mdl[dispatch_rob_id].rm = 0; mdl[dispatch_rob_id].wm = 0;
    end
    if (wb_valid) begin
      mdl[wb_rob_id].done = 1;
      mdl[wb_rob_id].rs1d = wb_rs1_rdata;
      mdl[wb_rob_id].rs2d = wb_rs2_rdata;
      mdl[wb_rob_id].rdw = wb_rd_wdata;
      mdl[wb_rob_id].pcw = wb_pc_wdata;
    end
    if (mem_valid) begin
      mdl[mem_rob_id].maddr = mem_addr; mdl[mem_rob_id].mrd = mem_rdata;
      mdl[mem_rob_id].mwd = mem_wdata;
      mdl[mem_rob_id].rm = mem_rmask; mdl[mem_rob_id].wm = mem_wmask;
    end
  endtask

  task automatic step();
    model_apply();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst = 1; step();
  endtask

  rec_t last;
  bit   live = 0;

  always @(posedge clk) begin
    rec_t act, exp;
    #1;
    act = {rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
           rvfi_mem_rmask, rvfi_mem_wmask};
    if (rst) begin
      live = 1;
      last = '0;
      expq.delete();
      chk("reset_valid", rvfi_valid, 0);
      chk("reset_error", error, 0);
      chk("reset_outputs", act, last);
    end else if (live) begin
      if (rvfi_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", rvfi_valid, 0);
        end else begin
          exp = expq.pop_front();
          chk("commit_record", act, exp);
          last = exp;
        end
      end else begin
        if (expq.size() != 0) begin
          chk("missing_valid", rvfi_valid, 1);
          void'(expq.pop_front());
        end
        chk("hold_outputs", act, last);
      end
    end
  end

  int q [$];
  int tail;

  initial begin
    idle();
    rst = 1; step(); step();
    for (int i = 0; i < D; i++) begin
      drv_disp(i, $urandom, $urandom, 5'(i), 5'(i + 1), 5'(i + 2));
      drv_wb(i, $urandom, $urandom, $urandom, $urandom);
      drv_mem(i, $urandom, $urandom, $urandom, 4'(i), 4'(i + 3));
      step();
    end

    do_reset();
    drv_disp(3, 32'h0050_0093, 32'h6000_0000, 5'd0, 5'd0, 5'd1);
    step();
    drv_wb(3, 32'd0, 32'd0, 32'd5, 32'h6000_0004);
    step();
    drv_commit(3);
    step();
    chk("t035_valid", rvfi_valid, 1);
    chk("t035_order", rvfi_order, 64'd0);
    chk("t035_rd_wdata", rvfi_rd_wdata, 32'h5);
    chk("t035_pc_rdata", rvfi_pc_rdata, 32'h6000_0000);

    do_reset();
    drv_disp(0, 32'h13, 32'h100, 5'd1, 5'd2, 5'd3); step();
    drv_disp(1, 32'h33, 32'h104, 5'd4, 5'd5, 5'd6);
    drv_wb(0, 32'h11, 32'h22, 32'h33, 32'h104); step();
    drv_wb(1, 32'h44, 32'h55, 32'h66, 32'h108); step();
    drv_commit(0); step();
    chk("t036_order0", rvfi_order, 64'd0);
    drv_commit(1); step();
    chk("t036_order1", rvfi_order, 64'd1);
    chk("t036_valid1", rvfi_valid, 1);
    step();
    chk("t036_valid_drop", rvfi_valid, 0);

    do_reset();
    drv_disp(5, 32'h0000_0533, 32'h200, 5'd1, 5'd2, 5'd10); step();
    drv_wb(5, 32'h1, 32'h2, 32'hDEAD_BEEF, 32'h204);
    drv_commit(5); step();
    chk("t037_bypass", rvfi_rd_wdata, 32'hDEAD_BEEF);

    do_reset();
    drv_disp(7, 32'h00B5_2223, 32'h300, 5'd10, 5'd11, 5'd0); step();
    drv_mem(7, 32'h1004, 32'h0, 32'h0000_ABCD, 4'b0000, 4'b0011);
    step();
    drv_wb(7, 32'h1000, 32'hABCD, 32'h1234, 32'h304);
    drv_commit(7); step();
    chk("t039_addr", rvfi_mem_addr, 32'h1004);
    chk("t039_wmask", rvfi_mem_wmask, 4'b0011);
    chk("t039_wdata", rvfi_mem_wdata, 32'h0000_ABCD);
    chk("t039_rmask", rvfi_mem_rmask, 4'b0000);
    chk("t039_rd_zero", rvfi_rd_wdata, 32'h0);
    chk("t039_error", error, 0);

    do_reset();
    drv_disp(8, 32'h1, 32'h400, 5'd1, 5'd1, 5'd1); step();
    drv_wb(8, 32'h7, 32'h7, 32'h7, 32'h404);
    drv_disp(9, 32'h2, 32'h404, 5'd2, 5'd2, 5'd2); step();
    drv_wb(9, 32'h8, 32'h8, 32'h8, 32'h408); step();
    force dut.order_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.order_q;
    cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drv_commit(8); step();
    chk("t040_order_max", rvfi_order, 64'hFFFF_FFFF_FFFF_FFFF);
    drv_commit(9); step();
    chk("t040_order_wrap", rvfi_order, 64'd0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv_disp(i, 32'h10 + i, 32'h500 + 4 * i, 5'd1, 5'd2, 5'(3 + i));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drv_wb(i, $urandom, $urandom, $urandom, $urandom);
      step();
    end
    drv_commit(0);
    flush = 1;
    drv_disp(4, 32'hFF, 32'h600, 5'd1, 5'd1, 5'd1);
    step();
    step();
    chk("t038_error_clean", error, 0);
    drv_commit(2); step();
    chk("t038_error_set", error, CHK);
    step();
    chk("t038_error_sticky", error, CHK);

    do_reset();
    chk("rand_error_cleared", error, 0);
    q.delete();
    tail = 0;
    for (int c = 0; c < 3000; c++) begin
      bit fl;
      int head;
      fl = ($urandom_range(0, 59) == 0);
      if (!fl && q.size() > 0 && $urandom_range(0, 1) == 1)
        drv_wb(q[$urandom_range(0, q.size() - 1)], $urandom, $urandom,
               $urandom, $urandom);
      if (!fl && q.size() > 0 && $urandom_range(0, 3) == 0)
        drv_mem(q[$urandom_range(0, q.size() - 1)], $urandom, $urandom,
                $urandom, 4'($urandom), 4'($urandom));
      if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
        head = q[0];
        if (mdl[head].done || (wb_valid && int'(wb_rob_id) == head)) begin
          drv_commit(head);
          void'(q.pop_front());
        end
      end
      if (!fl && q.size() < D && $urandom_range(0, 9) < 6) begin
        drv_disp(tail, $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
        q.push_back(tail);
        tail = (tail + 1) % D;
      end
      if (fl) begin
        flush = 1;
        q.delete();
      end
      step();
    end
    step();
    step();
    chk("rand_error", error, 0);
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_tracker.md
RVFI_COMMIT_TRACKER -- requirements
Module: rvfi_commit_tracker

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, meaning ROB entries tracked; power of 2, ≥ 4.
REQ-002 SHALL have localparam IDX_W = clog2(ROB_DEPTH).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 dispatch_valid  in  1, plus dispatch_rob_id  in  IDX_W  entry allocated this cycle.
REQ-006 dispatch_inst, dispatch_pc  in  32 each; dispatch_rs1_addr, dispatch_rs2_addr, dispatch_rd_addr  in  5 each.
REQ-007 wb_valid  in  1, plus wb_rob_id  in  IDX_W  execution result for an entry.
REQ-008 wb_rs1_rdata, wb_rs2_rdata, wb_rd_wdata, wb_pc_wdata  in  32 each.
REQ-009 mem_valid  in  1, plus mem_rob_id  in  IDX_W  memory access record for an entry.
REQ-010 mem_addr, mem_rdata, mem_wdata  in  32 each; mem_rmask, mem_wmask  in  4 each.
REQ-011 commit_valid  in  1, plus commit_rob_id  in  IDX_W  entry retiring this cycle.
REQ-012 flush  in  1  discard all uncommitted entries.
REQ-013 rvfi_valid  out  1; rvfi_order  out  64; rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata  out  32 each.
REQ-014 rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  5 each; rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  out  32 each.
REQ-015 rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  out  32 each; rvfi_mem_rmask, rvfi_mem_wmask  out  4 each.
REQ-016 error  out  1  sticky protocol violation flag.

Function
REQ-017 Each entry SHALL hold fields from REQ-006/008/010 plus bits alloc, done.
REQ-018 On dispatch_valid, entry SHALL store the dispatch fields, set alloc=1, done=0, and clear mem masks to 0.
REQ-019 On wb_valid, entry SHALL store the wb fields and set done=1.
REQ-020 On mem_valid, entry SHALL store the mem fields; it does not affect done.
REQ-021 On commit_valid, all rvfi_* outputs SHALL be registered from the entry at the next edge, so latency is 1 cycle, and alloc SHALL be cleared.
REQ-022 rvfi_valid SHALL be high exactly one cycle per commit; with no commit, rvfi_valid=0 and other outputs hold their last values.
REQ-023 rvfi_order SHALL equal a 64-bit counter, starting at 0 and incrementing after each emitted commit; it wraps modulo 2^64.
REQ-024 rvfi_rd_wdata SHALL be 0 when rvfi_rd_addr=0; rvfi_rsN_rdata SHALL be 0 when rvfi_rsN_addr=0.
REQ-025 Bypass: if wb_valid or mem_valid targets commit_rob_id in the commit cycle, the new data SHALL be emitted.
REQ-026 Dispatch and commit to the same id in one cycle: commit SHALL emit the old contents; the entry then holds the new dispatch with alloc=1.
REQ-027 Flush SHALL clear all alloc bits at the edge.
REQ-028 A commit in the flush cycle SHALL still be emitted.
REQ-029 A dispatch, wb or mem in the flush cycle SHALL be ignored.
REQ-030 Only one commit per cycle; entries have no ordering logic, and the ROB guarantees program order of commit_rob_id.

Reset
REQ-031 On rst: all alloc/done=0, order counter=0, rvfi_valid=0, error=0, all other rvfi_* outputs=0.
REQ-032 rst SHALL dominate every input in the same cycle; in-flight entries are lost and no rvfi_valid follows.

Configuration
REQ-033 Macro RVFI_TRACKER_CHECK_EN, when defined, SHALL set error (sticky until rst) on any of: commit to an entry with alloc=0 or done=0 (after bypass); dispatch to an entry with alloc=1 not committing that cycle; wb/mem to an entry with alloc=0.
REQ-034 With RVFI_TRACKER_CHECK_EN undefined, error SHALL be constant 0 and no check logic SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-035 Reset, dispatch id 3 (inst 0x00500093, pc 0x60000000, rd 1), wb rd_wdata 5, commit 3 -> next cycle rvfi_valid=1, order=0, rd_wdata=0x5, pc_rdata=0x60000000.
REQ-036 Two commits of ids 0,1 in consecutive cycles -> rvfi_valid high 2 cycles, orders 0 and 1.
REQ-037 wb and commit to id 5 in same cycle with rd_wdata 0xDEADBEEF -> emitted rd_wdata=0xDEADBEEF.
REQ-038 Dispatch ids 0-3, flush with commit 0 same cycle -> one rvfi_valid for id 0; later commit id 2 with CHECK_EN -> error=1.
REQ-039 Store to id 7 with mem_addr 0x1004, wmask 4'b0011, wdata 0x0000ABCD -> emitted mem fields match exactly; rd_addr 0 gives rd_wdata=0.
REQ-040 Order counter preloaded to 2^64-1 via force, one commit -> order 0xFFFF_FFFF_FFFF_FFFF, next commit order 0.
